// File: rtl/axi_sram_responder.sv
// AXI-lite style word SRAM responder with programmable read/write response latency.
// One transaction outstanding at a time; a write (AW/W) always wins over a pending read.
module axi_sram_responder #(
  parameter int                  DATA_LEN  = 32,
  parameter int                  ADDR_LEN  = 32,
  parameter int                  DEPTH     = 256,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                  RD_LAT    = 1,
  parameter int                  WR_LAT    = 1
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] addr_r_addr_i,
  input  logic                addr_r_valid_i,
  output logic                addr_r_ready_o,
  input  logic [2:0]          addr_r_size_i,
  output logic [DATA_LEN-1:0] r_data_o,
  output logic [1:0]          r_resp_o,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  input  logic [ADDR_LEN-1:0] addr_w_addr_i,
  input  logic                addr_w_valid_i,
  input  logic [2:0]          addr_w_size_i,
  output logic                addr_w_ready_o,
  input  logic [DATA_LEN-1:0] w_data_i,
  input  logic [3:0]          w_strb_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  output logic [1:0]          bkwd_resp_o,
  output logic                bkwd_valid_o,
  input  logic                bkwd_ready_i
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [2:0] {IDLE, W_COLLECT, W_WAIT, B_RESP, R_WAIT, R_RESP} state_t;

  state_t               state_q, state_d;
  logic                 aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     wa_idx_q, ra_idx_q;
  logic                 wa_hit_q, ra_hit_q;
  logic [DATA_LEN-1:0]  wd_q;
  logic [3:0]           ws_q;
  logic [DATA_LEN-1:0]  r_data_q;
  logic [1:0]           r_resp_q, b_resp_q;
  logic                 r_valid_q, b_valid_q;
  logic [DATA_LEN-1:0]  mem_q [DEPTH];

  logic                 aw_rdy, w_rdy, ar_rdy;
  logic                 aw_hs, w_hs, ar_hs;
  logic                 r_load, b_load, mem_we;
  logic [ADDR_LEN-1:0]  ar_off, aw_off;
  logic                 ar_hit, aw_hit;

  // Below-base addresses wrap to a huge offset and therefore miss.
  assign ar_off = addr_r_addr_i - BASE_ADDR;
  assign aw_off = addr_w_addr_i - BASE_ADDR;
  assign ar_hit = (ar_off < ADDR_LEN'(DEPTH * 4)) && (addr_r_size_i <= 3'd2);
  assign aw_hit = (aw_off < ADDR_LEN'(DEPTH * 4)) && (addr_w_size_i <= 3'd2);

  always_comb begin
    state_d  = state_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    cnt_d    = cnt_q;
    aw_rdy   = 1'b0;
    w_rdy    = 1'b0;
    ar_rdy   = 1'b0;
    r_load   = 1'b0;
    b_load   = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE, W_COLLECT: begin
        aw_rdy = ~aw_got_q & ~rst;
        w_rdy  = ~w_got_q & ~rst;
        ar_rdy = (state_q == IDLE) & ~aw_got_q & ~w_got_q &
                 ~addr_w_valid_i & ~w_valid_i & ~rst;
        aw_got_d = aw_got_q | (addr_w_valid_i & aw_rdy);
        w_got_d  = w_got_q | (w_valid_i & w_rdy);
        if (aw_got_d && w_got_d) begin
          state_d = W_WAIT;
          cnt_d   = CNT_W'(WR_LAT - 1);
        end else if (aw_got_d || w_got_d) begin
          state_d = W_COLLECT;
        end else if (addr_r_valid_i && ar_rdy) begin
          state_d = R_WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      R_WAIT: begin
        if (cnt_q == '0) begin
          r_load  = 1'b1;
          state_d = R_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      R_RESP: if (r_ready_i) state_d = IDLE;
      W_WAIT: begin
        if (cnt_q == '0) begin
          mem_we  = wa_hit_q;
          b_load  = 1'b1;
          state_d = B_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      B_RESP: begin
        if (bkwd_ready_i) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign aw_hs = addr_w_valid_i & aw_rdy;
  assign w_hs  = w_valid_i & w_rdy;
  assign ar_hs = addr_r_valid_i & ar_rdy;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      cnt_q     <= '0;
      wa_idx_q  <= '0;
      wa_hit_q  <= 1'b0;
      ra_idx_q  <= '0;
      ra_hit_q  <= 1'b0;
      wd_q      <= '0;
      ws_q      <= '0;
      r_data_q  <= '0;
      r_resp_q  <= 2'b00;
      r_valid_q <= 1'b0;
      b_resp_q  <= 2'b00;
      b_valid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      cnt_q    <= cnt_d;
      if (aw_hs) begin
        wa_idx_q <= aw_off[IDX_W+1:2];
        wa_hit_q <= aw_hit;
      end
      if (w_hs) begin
        wd_q <= w_data_i;
        ws_q <= w_strb_i;
      end
      if (ar_hs) begin
        ra_idx_q <= ar_off[IDX_W+1:2];
        ra_hit_q <= ar_hit;
      end
      if (r_load) begin
        r_data_q  <= ra_hit_q ? mem_q[ra_idx_q] : '0;
        r_resp_q  <= ra_hit_q ? 2'b00 : 2'b10;
        r_valid_q <= 1'b1;
      end else if (state_q == R_RESP && r_ready_i) begin
        r_valid_q <= 1'b0;
      end
      if (b_load) begin
        b_resp_q  <= wa_hit_q ? 2'b00 : 2'b10;
        b_valid_q <= 1'b1;
      end else if (state_q == B_RESP && bkwd_ready_i) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  // Storage is deliberately left out of reset; state_q is forced to IDLE so no commit survives rst.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ws_q[b]) mem_q[wa_idx_q][8*b +: 8] <= wd_q[8*b +: 8];
      end
    end
  end

  assign addr_r_ready_o = ar_rdy;
  assign addr_w_ready_o = aw_rdy;
  assign w_ready_o      = w_rdy;
  assign r_data_o       = r_data_q;
  assign r_resp_o       = r_resp_q;
  assign r_valid_o      = r_valid_q;
  assign bkwd_resp_o    = b_resp_q;
  assign bkwd_valid_o   = b_valid_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder: two instances (RD/WR latency 1/1 and 4/3) driven by one scoreboard.
module tb_axi_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        rst      [2];
  logic [31:0] ar_addr  [2];
  logic        ar_valid [2];
  logic        ar_ready [2];
  logic [2:0]  ar_size  [2];
  logic [31:0] r_data   [2];
  logic [1:0]  r_resp   [2];
  logic        r_valid  [2];
  logic        r_ready  [2];
  logic [31:0] aw_addr  [2];
  logic        aw_valid [2];
  logic [2:0]  aw_size  [2];
  logic        aw_ready [2];
  logic [31:0] w_data   [2];
  logic [3:0]  w_strb   [2];
  logic        w_valid  [2];
  logic        w_ready  [2];
  logic [1:0]  b_resp   [2];
  logic        b_valid  [2];
  logic        b_ready  [2];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_sram_responder #(
      .RD_LAT(g == 0 ? 1 : 4),
      .WR_LAT(g == 0 ? 1 : 3)
    ) u_dut (
      .clock         (clock),
      .rst           (rst[g]),
      .addr_r_addr_i (ar_addr[g]),
      .addr_r_valid_i(ar_valid[g]),
      .addr_r_ready_o(ar_ready[g]),
      .addr_r_size_i (ar_size[g]),
      .r_data_o      (r_data[g]),
      .r_resp_o      (r_resp[g]),
      .r_valid_o     (r_valid[g]),
      .r_ready_i     (r_ready[g]),
      .addr_w_addr_i (aw_addr[g]),
      .addr_w_valid_i(aw_valid[g]),
      .addr_w_size_i (aw_size[g]),
      .addr_w_ready_o(aw_ready[g]),
      .w_data_i      (w_data[g]),
      .w_strb_i      (w_strb[g]),
      .w_valid_i     (w_valid[g]),
      .w_ready_o     (w_ready[g]),
      .bkwd_resp_o   (b_resp[g]),
      .bkwd_valid_o  (b_valid[g]),
      .bkwd_ready_i  (b_ready[g])
    );
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [33:0] rq [$];
  logic [1:0]  bq [$];
  logic [31:0] mdl [2][256];

  function automatic int rdl(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int wrl(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic is_hit(input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] off;
    off = a - BASE;
    return (off < 32'd1024) && (sz <= 3'd2);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] sz, input int gap,
                          input logic with_ar);
    logic [31:0] off;
    logic [1:0]  exp;
    int          lat;
    off = a - BASE;
    if (is_hit(a, sz))
      for (int b = 0; b < 4; b++) if (s[b]) mdl[k][off[9:2]][8*b +: 8] = d[8*b +: 8];
    bq.push_back(is_hit(a, sz) ? 2'b00 : 2'b10);
    @(negedge clock);
    aw_valid[k] = 1'b1; aw_addr[k] = a; aw_size[k] = sz;
    if (with_ar) begin
      ar_valid[k] = 1'b1; ar_addr[k] = a; ar_size[k] = 3'd2;
    end
    if (gap == 0) begin
      w_valid[k] = 1'b1; w_data[k] = d; w_strb[k] = s;
    end
    #1;
    check("aw_rdy", aw_ready[k], 1);
    check("ar_blocked_by_w", ar_ready[k], 0);
    @(posedge clock); #1;
    aw_valid[k] = 1'b0;
    if (gap == 0) begin
      w_valid[k] = 1'b0;
    end else begin
      for (int i = 1; i < gap; i++) begin
        check("aw_rdy_low_split", aw_ready[k], 0);
        check("w_rdy_open_split", w_ready[k], 1);
        @(posedge clock); #1;
      end
      w_valid[k] = 1'b1; w_data[k] = d; w_strb[k] = s;
      #1;
      check("w_rdy_late", w_ready[k], 1);
      check("aw_rdy_low_at_w", aw_ready[k], 0);
      @(posedge clock); #1;
      w_valid[k] = 1'b0;
    end
    lat = 0;
    while (!b_valid[k] && lat < 50) begin
      @(posedge clock); lat++; #1;
    end
    check("b_latency", lat, wrl(k));
    exp = bq.pop_front();
    check("b_resp", b_resp[k], exp);
    b_ready[k] = 1'b1;
    @(posedge clock); #1;
    b_ready[k] = 1'b0;
    check("b_valid_drop", b_valid[k], 0);
  endtask

  task automatic do_read(input int k, input logic [31:0] a, input logic [2:0] sz, input int bp);
    logic [31:0] off;
    logic [33:0] exp;
    logic [31:0] held;
    int          n, lat;
    off = a - BASE;
    rq.push_back(is_hit(a, sz) ? {2'b00, mdl[k][off[9:2]]} : {2'b10, 32'h0});
    @(negedge clock);
    ar_valid[k] = 1'b1; ar_addr[k] = a; ar_size[k] = sz;
    #1;
    n = 0;
    while (!ar_ready[k] && n < 50) begin
      @(negedge clock); #1; n++;
    end
    check("ar_rdy", ar_ready[k], 1);
    @(posedge clock); #1;
    ar_valid[k] = 1'b0;
    lat = 0;
    while (!r_valid[k] && lat < 50) begin
      @(posedge clock); lat++; #1;
    end
    check("r_latency", lat, rdl(k));
    held = r_data[k];
    for (int i = 0; i < bp; i++) begin
      ar_valid[k] = 1'b1; ar_addr[k] = BASE;
      @(posedge clock); #1;
      check("r_valid_hold", r_valid[k], 1);
      check("r_data_stable", r_data[k], held);
      check("ar_rdy_low_in_resp", ar_ready[k], 0);
    end
    ar_valid[k] = 1'b0;
    exp = rq.pop_front();
    check("r_data", r_data[k], exp[31:0]);
    check("r_resp", r_resp[k], exp[33:32]);
    r_ready[k] = 1'b1;
    @(posedge clock); #1;
    r_ready[k] = 1'b0;
    check("r_valid_drop", r_valid[k], 0);
  endtask

  task automatic rst_mid_write(input int k, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    aw_valid[k] = 1'b1; aw_addr[k] = a; aw_size[k] = 3'd2;
    w_valid[k] = 1'b1; w_data[k] = d; w_strb[k] = 4'hF;
    @(posedge clock); #1;
    aw_valid[k] = 1'b0; w_valid[k] = 1'b0;
    rst[k] = 1'b1;
    #1;
    check("rst_b_valid", b_valid[k], 0);
    check("rst_aw_rdy", aw_ready[k], 0);
    check("rst_w_rdy", w_ready[k], 0);
    check("rst_ar_rdy", ar_ready[k], 0);
    @(negedge clock);
    rst[k] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check("no_b_after_rst", b_valid[k], 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      ar_addr[k] = '0; ar_valid[k] = 1'b0; ar_size[k] = '0; r_ready[k] = 1'b0;
      aw_addr[k] = '0; aw_valid[k] = 1'b0; aw_size[k] = '0;
      w_data[k] = '0; w_strb[k] = '0; w_valid[k] = 1'b0; b_ready[k] = 1'b0;
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      check("reset_r_valid", r_valid[k], 0);
      check("reset_b_valid", b_valid[k], 0);
      check("reset_r_data", r_data[k], 0);
      check("reset_r_resp", r_resp[k], 0);
      check("reset_b_resp", b_resp[k], 0);
      check("reset_ar_rdy", ar_ready[k], 0);
      check("reset_aw_rdy", aw_ready[k], 0);
      check("reset_w_rdy", w_ready[k], 0);
    end
    repeat (3) @(negedge clock);
    rst[0] = 1'b0; rst[1] = 1'b0;

    for (int k = 0; k < 2; k++) begin
      do_write(k, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 3'd2, 0, 1'b0);
      do_read (k, 32'h8000_0010, 3'd2, 0);
      do_write(k, 32'h8000_0011, 32'h0000_5500, 4'b0010, 3'd0, 0, 1'b0);
      do_read (k, 32'h8000_0010, 3'd2, 0);
      do_write(k, 32'h8000_0020, 32'h1234_5678, 4'hF, 3'd2, 3, 1'b0);
      do_read (k, 32'h8000_0020, 3'd2, 5);
      do_read (k, 32'h8000_0400, 3'd2, 0);
      do_read (k, 32'h7FFF_FFFC, 3'd2, 0);
      do_write(k, 32'h8000_0010, 32'h0000_0000, 4'hF, 3'd3, 0, 1'b0);
      do_read (k, 32'h8000_0010, 3'd2, 0);
      do_write(k, 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 3'd2, 1, 1'b0);
      do_read (k, 32'h8000_0020, 3'd2, 1);
      do_write(k, 32'h8000_03FC, 32'hA5A5_0F0F, 4'hF, 3'd2, 2, 1'b0);
      do_read (k, 32'h8000_03FE, 3'd1, 0);
      do_write(k, 32'h8000_0030, 32'hCAFE_F00D, 4'hF, 3'd2, 0, 1'b1);
      do_read (k, 32'h8000_0030, 3'd2, 0);
      rst_mid_write(k, 32'h8000_0030, 32'h0BAD_0BAD);
      do_read (k, 32'h8000_0030, 3'd2, 0);
      for (int i = 0; i < 6; i++) begin
        logic [31:0] ra;
        logic [31:0] rd;
        logic [3:0]  rs;
        ra = BASE + {22'd0, 8'($urandom_range(64, 255)), 2'b00};
        rd = $urandom;
        rs = 4'($urandom);
        do_write(k, ra, 32'hFFFF_FFFF, 4'hF, 3'd2, 0, 1'b0);
        do_write(k, ra, rd, rs, 3'd2, $urandom_range(0, 2), 1'b0);
        do_read (k, ra, 3'd2, $urandom_range(0, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_sram_responder.md
Name: axi_sram_responder

Overview:
- AXI-lite style memory responder (slave). It sits on the far end of the LSU data-memory port and serves the LSU's AR/R/AW/W/B channel signals.
- Contents: word-organised register-array memory with programmable read and write response latency.
- Used as the simulation and FPGA data-SRAM target, and as a handshake-stress target for the LSU.

Parameters:
- DATA_LEN, 32, data width in bits; fixed at 32 (strobe is 4 bits).
- ADDR_LEN, 32, address width.
- DEPTH, 256, number of 32-bit words; power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LAT, 1, cycles from AR handshake to r_valid rising; minimum 1.
- WR_LAT, 1, cycles from both AW and W captured to bkwd_valid rising; minimum 1.

Ports:
- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- addr_r_addr_i  in  ADDR_LEN  read address.
- addr_r_valid_i  in  1  read address valid.
- addr_r_ready_o  out  1  read address accepted.
- addr_r_size_i  in  3  log2 bytes (0/1/2 legal).
- r_data_o  out  DATA_LEN  read data (full aligned word).
- r_resp_o  out  2  00 OKAY, 10 SLVERR.
- r_valid_o  out  1  read data valid.
- r_ready_i  in  1  master accepts read data.
- addr_w_addr_i  in  ADDR_LEN  write address.
- addr_w_valid_i  in  1  write address valid.
- addr_w_size_i  in  3  log2 bytes.
- addr_w_ready_o  out  1  write address accepted.
- w_data_i  in  DATA_LEN  write data, already lane-shifted by master.
- w_strb_i  in  4  byte enables.
- w_valid_i  in  1  write data valid.
- w_ready_o  out  1  write data accepted.
- bkwd_resp_o  out  2  write response.
- bkwd_valid_o  out  1  write response valid.
- bkwd_ready_i  in  1  master accepts write response.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all valid outputs 0; all ready outputs forced 0 while rst=1.
  - r_data_o=0; r_resp_o=0; bkwd_resp_o=0; aw_got=0; w_got=0; latency counter=0.
  - Memory array is NOT reset.
- States: IDLE, W_COLLECT, W_WAIT, B_RESP, R_WAIT, R_RESP.
- Address decode:
  - off = addr - BASE_ADDR; hit = (off < DEPTH*4) and (size <= 2).
  - index = off[log2(DEPTH)+1:2]; addr[1:0] is ignored for indexing.
- IDLE / W_COLLECT, write path:
  - addr_w_ready_o = ~aw_got; w_ready_o = ~w_got.
  - AW and W are captured independently on valid&ready; the state is W_COLLECT while exactly one of the two is held.
  - When both are held (same cycle or different cycles): go to W_WAIT, load counter = WR_LAT-1.
- IDLE, read path:
  - addr_r_ready_o = 1 only when aw_got=0, w_got=0, addr_w_valid_i=0 and w_valid_i=0. Write has priority; a read is never accepted in the same cycle as an AW or W beat.
  - On AR handshake: capture address and hit; go to R_WAIT with counter = RD_LAT-1.
- Outside IDLE/W_COLLECT all readies are 0. Exactly one transaction is outstanding at a time.
- R_WAIT:
  - Counter decrements each cycle. At 0: r_data_o = hit ? mem[index] : 32'h0, r_resp_o = hit ? 00 : 10, r_valid_o=1 from the next cycle; go to R_RESP.
  - Net latency is RD_LAT cycles after the AR handshake edge.
- R_RESP:
  - r_valid_o, r_data_o and r_resp_o are held stable until r_ready_i=1; on that handshake go to IDLE with r_valid_o=0 next cycle.
- W_WAIT:
  - At counter 0 the commit happens: if hit, each byte lane b with w_strb_i[b]=1 is written mem[index][8b+7:8b] <= w_data[8b+7:8b]; lanes with strb 0 are unchanged.
  - Miss: no write. bkwd_resp_o = hit ? 00 : 10; bkwd_valid_o=1 next cycle; go to B_RESP.
- B_RESP: hold until bkwd_ready_i=1; then clear aw_got/w_got and go to IDLE.
- Strobe 4'b0000 with a hit: OKAY response, memory unchanged.
- A read immediately after a write to the same word returns the new data, because the commit precedes B_RESP.
- Reset mid-transaction: an uncommitted write is dropped, an in-flight read is abandoned, and all outputs return to reset values immediately (asynchronously).
- Counters are width clog2(max(RD_LAT,WR_LAT))+1 and do not wrap.

Test Plan:
- Write then read, full word:
  - AW=0x8000_0010, W=0xDEADBEEF, strb=1111, size=2; then AR 0x8000_0010 -> B resp 00.
  - r_data=0xDEADBEEF, r_resp=00, r_valid rises RD_LAT=1 cycle after the AR handshake.
- Byte store:
  - After the write above, sb at 0x8000_0011 with w_data=0x0000_5500, strb=0010 -> read of 0x8000_0010 returns 0xDEAD55EF.
- Split AW/W:
  - AW at cycle 0, W at cycle 3 -> addr_w_ready_o=0 in cycles 1-3, w_ready_o=1 until cycle 3.
  - bkwd_valid rises WR_LAT cycles after cycle 3.
- Backpressure:
  - RD_LAT=4; hold r_ready_i=0 for 5 cycles after r_valid rises -> r_valid and r_data stay stable.
  - addr_r_ready_o stays 0 until the handshake.
- Error response:
  - AR 0x8000_0400 (DEPTH=256) -> r_resp=10, r_data=0.
  - AW with size=3 -> bkwd_resp=10, memory unchanged.
- Priority and reset:
  - AR and AW+W valid in the same cycle -> write is served first, read is accepted after B_RESP.
  - rst asserted during W_WAIT -> bkwd_valid never rises and the target word keeps its old value.
